// File: rtl/pulse_scheduler.sv
// Multi-channel timestamp-driven pulse queue: per-channel FIFOs issue their head once the shared time counter reaches it.
// Optional per-channel flush input is enabled by defining PULSE_SCHED_FLUSH_EN.
module pulse_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 16,
  parameter int PHASE_W = 16,
  parameter int AMP_W   = 16,
  parameter int FREQ_W  = 24,
  parameter int TIME_W  = 32,
  parameter int TLEN_W  = 16,
  parameter int ENV_W   = 10,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      time_clr,
  output logic [TIME_W-1:0]         now,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [PHASE_W-1:0]        wr_phase,
  input  logic [AMP_W-1:0]          wr_amp,
  input  logic [FREQ_W-1:0]         wr_freq,
  input  logic [TIME_W-1:0]         wr_tstart,
  input  logic [TLEN_W-1:0]         wr_tlen,
  input  logic [ENV_W-1:0]          wr_env_addr,
  output logic [NUM_CH-1:0]         pulse_valid,
  input  logic [NUM_CH-1:0]         pulse_ready,
  output logic [NUM_CH*PHASE_W-1:0] rd_phase,
  output logic [NUM_CH*AMP_W-1:0]   rd_amp,
  output logic [NUM_CH*FREQ_W-1:0]  rd_freq,
  output logic [NUM_CH*TIME_W-1:0]  rd_tstart,
  output logic [NUM_CH*TLEN_W-1:0]  rd_tlen,
  output logic [NUM_CH*ENV_W-1:0]   rd_env_addr,
  output logic [NUM_CH-1:0]         full,
  output logic [NUM_CH-1:0]         empty,
  output logic [NUM_CH-1:0]         late,
  input  logic [NUM_CH-1:0]         late_clr
`ifdef PULSE_SCHED_FLUSH_EN
  ,
  input  logic [NUM_CH-1:0]         flush
`endif
);

  localparam int AW       = $clog2(DEPTH);
  localparam int ENV_LSB  = 0;
  localparam int TLEN_LSB = ENV_LSB + ENV_W;
  localparam int TST_LSB  = TLEN_LSB + TLEN_W;
  localparam int FREQ_LSB = TST_LSB + TIME_W;
  localparam int AMP_LSB  = FREQ_LSB + FREQ_W;
  localparam int PH_LSB   = AMP_LSB + AMP_W;
  localparam int DESC_W   = PH_LSB + PHASE_W;

  logic [TIME_W-1:0] now_reg;
  logic [DESC_W-1:0] wr_desc;
  logic [NUM_CH-1:0] flush_int;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] ch_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      now_reg <= '0;
    end else if (time_clr) begin
      now_reg <= '0;
    end else if (run) begin
      now_reg <= now_reg + 1'b1;
    end
  end

  assign now     = now_reg;
  assign wr_desc = {wr_phase, wr_amp, wr_freq, wr_tstart, wr_tlen, wr_env_addr};

`ifdef PULSE_SCHED_FLUSH_EN
  assign flush_int = flush;
`else
  assign flush_int = '0;
`endif

  // Out-of-range channel numbers match no channel, so they never see ready.
  assign wr_ready = |(ch_hit & ~ch_full);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [AW:0]         wr_ptr_reg;
      logic [AW:0]         rd_ptr_reg;
      logic [DESC_W-1:0]   mem [DEPTH];
      logic [DESC_W-1:0]   head;
      logic [DESC_W-1:0]   out_reg;
      logic                valid_reg;
      logic                late_reg;
      logic [TIME_W-1:0]   d;
      logic                ch_empty;
      logic                push;
      logic                pop;

      assign ch_hit[gi]  = (wr_ch == CH_W'(gi));
      assign ch_empty    = (wr_ptr_reg == rd_ptr_reg);
      assign ch_full[gi] = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                           (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

      // Asynchronous head read so a due head can pop in the cycle it becomes due.
      assign head = mem[rd_ptr_reg[AW-1:0]];
      assign d    = now_reg - head[TST_LSB +: TIME_W];

      assign push = wr_valid && ch_hit[gi] && !ch_full[gi] && !flush_int[gi];
      assign pop  = !ch_empty && !d[TIME_W-1] && (!valid_reg || pulse_ready[gi]) &&
                    !flush_int[gi];

      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_reg[AW-1:0]] <= wr_desc;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          valid_reg  <= 1'b0;
          late_reg   <= 1'b0;
          out_reg    <= '0;
        end else if (flush_int[gi]) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          valid_reg  <= 1'b0;
          if (late_clr[gi]) begin
            late_reg <= 1'b0;
          end
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            out_reg    <= head;
            valid_reg  <= 1'b1;
          end else if (pulse_ready[gi]) begin
            valid_reg <= 1'b0;
          end
          // A late issue in the same cycle as a clear keeps the flag set.
          if (pop && (d != '0)) begin
            late_reg <= 1'b1;
          end else if (late_clr[gi]) begin
            late_reg <= 1'b0;
          end
        end
      end

      assign pulse_valid[gi] = valid_reg;
      assign late[gi]        = late_reg;
      assign full[gi]        = ch_full[gi];
      assign empty[gi]       = ch_empty;

      assign rd_phase[gi*PHASE_W +: PHASE_W]  = out_reg[PH_LSB   +: PHASE_W];
      assign rd_amp[gi*AMP_W +: AMP_W]        = out_reg[AMP_LSB  +: AMP_W];
      assign rd_freq[gi*FREQ_W +: FREQ_W]     = out_reg[FREQ_LSB +: FREQ_W];
      assign rd_tstart[gi*TIME_W +: TIME_W]   = out_reg[TST_LSB  +: TIME_W];
      assign rd_tlen[gi*TLEN_W +: TLEN_W]     = out_reg[TLEN_LSB +: TLEN_W];
      assign rd_env_addr[gi*ENV_W +: ENV_W]   = out_reg[ENV_LSB  +: ENV_W];
    end
  endgenerate

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: directed scenarios plus randomized traffic against a queue-based model.
module tb_pulse_scheduler;

  localparam int NCH = 5;
  localparam int DEP = 16;
  localparam int PW  = 16;
  localparam int AWD = 16;
  localparam int FW  = 24;
  localparam int TW  = 10;
  localparam int LW  = 16;
  localparam int EW  = 10;
  localparam int CW  = 3;

  typedef struct packed {
    logic [PW-1:0]  phase;
    logic [AWD-1:0] amp;
    logic [FW-1:0]  freq;
    logic [TW-1:0]  tstart;
    logic [LW-1:0]  tlen;
    logic [EW-1:0]  env;
  } desc_t;

  logic clk = 1'b0;
  logic rst, run, time_clr, wr_valid;
  logic [CW-1:0] wr_ch;
  logic [PW-1:0] wr_phase;
  logic [AWD-1:0] wr_amp;
  logic [FW-1:0] wr_freq;
  logic [TW-1:0] wr_tstart;
  logic [LW-1:0] wr_tlen;
  logic [EW-1:0] wr_env_addr;
  logic [NCH-1:0] pulse_ready, late_clr, flush_v;
  logic [TW-1:0] now;
  logic wr_ready;
  logic [NCH-1:0] pulse_valid, full, empty, late;
  logic [NCH*PW-1:0] rd_phase;
  logic [NCH*AWD-1:0] rd_amp;
  logic [NCH*FW-1:0] rd_freq;
  logic [NCH*TW-1:0] rd_tstart;
  logic [NCH*LW-1:0] rd_tlen;
  logic [NCH*EW-1:0] rd_env_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  desc_t mq [NCH][$];
  desc_t mout [NCH];
  bit [NCH-1:0] mvalid, mlate;
  logic [TW-1:0] mnow;

  always #5 clk = ~clk;

  pulse_scheduler #(
    .NUM_CH(NCH), .DEPTH(DEP), .PHASE_W(PW), .AMP_W(AWD), .FREQ_W(FW),
    .TIME_W(TW), .TLEN_W(LW), .ENV_W(EW)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .time_clr(time_clr), .now(now),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_phase(wr_phase), .wr_amp(wr_amp), .wr_freq(wr_freq),
    .wr_tstart(wr_tstart), .wr_tlen(wr_tlen), .wr_env_addr(wr_env_addr),
    .pulse_valid(pulse_valid), .pulse_ready(pulse_ready),
    .rd_phase(rd_phase), .rd_amp(rd_amp), .rd_freq(rd_freq),
    .rd_tstart(rd_tstart), .rd_tlen(rd_tlen), .rd_env_addr(rd_env_addr),
    .full(full), .empty(empty), .late(late), .late_clr(late_clr)
`ifdef PULSE_SCHED_FLUSH_EN
    , .flush(flush_v)
`endif
  );

  function automatic bit m_due(input logic [TW-1:0] ts);
    logic [TW-1:0] d;
    d = mnow - ts;
    return int'(d) < (1 << (TW - 1));
  endfunction

  function automatic bit m_wr_ready();
    if (int'(wr_ch) >= NCH) return 1'b0;
    return mq[wr_ch].size() < DEP;
  endfunction

  function automatic desc_t rand_desc(input logic [TW-1:0] ts);
    desc_t x;
    x.phase  = PW'($urandom);
    x.amp    = AWD'($urandom);
    x.freq   = FW'($urandom);
    x.tstart = ts;
    x.tlen   = LW'($urandom);
    x.env    = EW'($urandom);
    return x;
  endfunction

  function automatic desc_t got_desc(input int c);
    desc_t g;
    g.phase  = rd_phase[c*PW +: PW];
    g.amp    = rd_amp[c*AWD +: AWD];
    g.freq   = rd_freq[c*FW +: FW];
    g.tstart = rd_tstart[c*TW +: TW];
    g.tlen   = rd_tlen[c*LW +: LW];
    g.env    = rd_env_addr[c*EW +: EW];
    return g;
  endfunction

  task automatic set_write(input int ch, input desc_t x);
    wr_valid    = 1'b1;
    wr_ch       = CW'(ch);
    wr_phase    = x.phase;
    wr_amp      = x.amp;
    wr_freq     = x.freq;
    wr_tstart   = x.tstart;
    wr_tlen     = x.tlen;
    wr_env_addr = x.env;
  endtask

  // Advance one clock; the model applies the same edge using the current inputs.
  task automatic tick();
    bit [NCH-1:0] pop;
    bit acc;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        mout[c] = '0;
      end
      mvalid = '0;
      mlate  = '0;
      mnow   = '0;
    end else begin
      acc = wr_valid && m_wr_ready();
      for (int c = 0; c < NCH; c++) begin
        pop[c] = !flush_v[c] && mq[c].size() > 0 && m_due(mq[c][0].tstart) &&
                 (!mvalid[c] || pulse_ready[c]);
        if (pop[c]) begin
          mout[c]   = mq[c].pop_front();
          mvalid[c] = 1'b1;
        end else if (pulse_ready[c]) begin
          mvalid[c] = 1'b0;
        end
        if (pop[c] && mout[c].tstart != mnow) mlate[c] = 1'b1;
        else if (late_clr[c]) mlate[c] = 1'b0;
      end
      if (acc && !flush_v[wr_ch]) begin
        mq[wr_ch].push_back(desc_t'({wr_phase, wr_amp, wr_freq, wr_tstart, wr_tlen, wr_env_addr}));
      end
      for (int c = 0; c < NCH; c++) begin
        if (flush_v[c]) begin
          mq[c].delete();
          mvalid[c] = 1'b0;
        end
      end
      if (time_clr) mnow = '0;
      else if (run) mnow = mnow + 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; time_clr = 1'b0; wr_valid = 1'b0; wr_ch = '0;
    wr_phase = '0; wr_amp = '0; wr_freq = '0; wr_tstart = '0; wr_tlen = '0; wr_env_addr = '0;
    pulse_ready = '0; late_clr = '0; flush_v = '0;
    tick();
    tick();
    checks++;
    if (now !== '0) begin errors++; $display("FAIL reset_now: got %0d, required 0", now); end
    checks++;
    if (pulse_valid !== '0 || late !== '0 || full !== '0) begin
      errors++; $display("FAIL reset_flags: valid=%b late=%b full=%b, required all 0", pulse_valid, late, full);
    end
    checks++;
    if (empty !== {NCH{1'b1}}) begin errors++; $display("FAIL reset_empty: got %b, required all 1", empty); end
    checks++;
    if (rd_tstart !== '0 || rd_amp !== '0 || rd_phase !== '0) begin
      errors++; $display("FAIL reset_rd: rd fields nonzero, required 0");
    end
    $display("reset: now=%0d valid=%b empty=%b", now, pulse_valid, empty);
    rst = 1'b0;
  endtask

  task automatic test_ontime();
    desc_t e;
    run = 1'b1;
    for (int i = 0; i < 10 && mnow != 3; i++) tick();
    e = rand_desc(10);
    set_write(0, e);
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL ontime_wr_ready: got %b, required 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 30 && !pulse_valid[0]; i++) tick();
    checks++;
    if (pulse_valid[0] !== 1'b1 || now !== 11) begin
      errors++; $display("FAIL ontime_issue: valid=%b now=%0d, required valid=1 now=11", pulse_valid[0], now);
    end
    checks++;
    if (got_desc(0) !== e || late[0] !== 1'b0) begin
      errors++; $display("FAIL ontime_data: tstart=%0d late=%b, required tstart=10 late=0", rd_tstart[TW-1:0], late[0]);
    end
    $display("ontime: ch0 issued tstart=%0d at now=%0d late=%b", rd_tstart[TW-1:0], now, late[0]);
    pulse_ready[0] = 1'b1;
    tick();
    pulse_ready[0] = 1'b0;
    checks++;
    if (pulse_valid[0] !== 1'b0) begin errors++; $display("FAIL ontime_consume: valid=%b, required 0", pulse_valid[0]); end
  endtask

  task automatic test_late();
    for (int i = 0; i < 100 && mnow != 50; i++) tick();
    set_write(1, rand_desc(0));
    tick();
    wr_valid = 1'b0;
    tick();
    checks++;
    if (pulse_valid[1] !== 1'b1 || late[1] !== 1'b1) begin
      errors++; $display("FAIL late_issue: valid=%b late=%b, required 1 1", pulse_valid[1], late[1]);
    end
    pulse_ready[1] = 1'b1;
    tick();
    pulse_ready[1] = 1'b0;
    checks++;
    if (late[1] !== 1'b1) begin errors++; $display("FAIL late_sticky: got %b, required 1", late[1]); end
    late_clr[1] = 1'b1;
    tick();
    late_clr[1] = 1'b0;
    checks++;
    if (late[1] !== 1'b0) begin errors++; $display("FAIL late_clr: got %b, required 0", late[1]); end
    $display("late: ch1 late flag cleared, late=%b", late);
  endtask

  task automatic test_full();
    logic [TW-1:0] tlist [DEP];
    logic [TW-1:0] base;
    int issued, first, last;
    run = 1'b0;
    base = mnow;
    for (int i = 0; i < DEP; i++) begin
      tlist[i] = base + TW'(5 + i);
      set_write(2, rand_desc(tlist[i]));
      #1;
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready%0d: got %b, required 1", i, wr_ready); end
      tick();
    end
    set_write(2, rand_desc(base));
    #1;
    checks++;
    if (wr_ready !== 1'b0 || full[2] !== 1'b1) begin
      errors++; $display("FAIL full_flag: wr_ready=%b full=%b, required 0 1", wr_ready, full[2]);
    end
    tick();
    wr_valid = 1'b0;
    run = 1'b1;
    pulse_ready[2] = 1'b1;
    issued = 0; first = 0; last = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (pulse_valid[2]) begin
        checks++;
        if (issued >= DEP || rd_tstart[2*TW +: TW] !== tlist[issued % DEP]) begin
          errors++; $display("FAIL full_order%0d: tstart=%0d, required %0d", issued, rd_tstart[2*TW +: TW], tlist[issued % DEP]);
        end
        if (issued == 0) first = cyc;
        last = cyc;
        issued++;
      end
    end
    pulse_ready[2] = 1'b0;
    checks++;
    if (issued != DEP || last - first != DEP - 1) begin
      errors++; $display("FAIL full_drain: issued=%0d span=%0d, required %0d %0d", issued, last - first, DEP, DEP - 1);
    end
    $display("full: ch2 drained %0d entries over %0d cycles", issued, last - first + 1);
  endtask

  task automatic test_back_to_back();
    desc_t e0, e1;
    logic [TW-1:0] base;
    run = 1'b1;
    base = mnow + 3;
    e0 = rand_desc(base);
    e1 = rand_desc(base);
    e1.amp = e0.amp ^ 16'h1;
    set_write(3, e0); tick();
    set_write(3, e1); tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 20 && !pulse_valid[3]; i++) tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pulse_valid[3] !== 1'b1 || got_desc(3) !== e0) begin
        errors++; $display("FAIL hold_stable%0d: valid=%b amp=%h, required 1 %h", i, pulse_valid[3], rd_amp[3*AWD +: AWD], e0.amp);
      end
      tick();
    end
    pulse_ready[3] = 1'b1;
    tick();
    checks++;
    if (pulse_valid[3] !== 1'b1 || got_desc(3) !== e1) begin
      errors++; $display("FAIL hold_release: valid=%b amp=%h, required 1 %h", pulse_valid[3], rd_amp[3*AWD +: AWD], e1.amp);
    end
    tick();
    pulse_ready[3] = 1'b0;
    checks++;
    if (pulse_valid[3] !== 1'b0) begin errors++; $display("FAIL hold_drain: valid=%b, required 0", pulse_valid[3]); end
    $display("back_to_back: ch3 held entry0 then advanced to entry1");
  endtask

  task automatic test_wrap();
    time_clr = 1'b1;
    tick();
    time_clr = 1'b0;
    checks++;
    if (now !== '0) begin errors++; $display("FAIL wrap_clr: now=%0d, required 0", now); end
    run = 1'b1;
    for (int i = 0; i < 1100 && mnow != TW'((1 << TW) - 2); i++) tick();
    set_write(0, rand_desc(1));
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 10 && !pulse_valid[0]; i++) tick();
    checks++;
    if (pulse_valid[0] !== 1'b1 || now !== 2 || late[0] !== 1'b0 || rd_tstart[TW-1:0] !== 1) begin
      errors++; $display("FAIL wrap_issue: valid=%b now=%0d late=%b tstart=%0d, required 1 2 0 1",
                         pulse_valid[0], now, late[0], rd_tstart[TW-1:0]);
    end
    $display("wrap: ch0 tstart=1 issued at now=%0d", now);
    pulse_ready[0] = 1'b1;
    tick();
    pulse_ready[0] = 1'b0;
  endtask

`ifdef PULSE_SCHED_FLUSH_EN
  task automatic test_flush();
    logic [TW-1:0] base;
    run = 1'b0;
    base = mnow;
    set_write(0, rand_desc(base)); tick();
    for (int i = 0; i < 5; i++) begin set_write(0, rand_desc(base + 100)); tick(); end
    set_write(1, rand_desc(base + 100)); tick();
    wr_valid = 1'b0;
    checks++;
    if (pulse_valid[0] !== 1'b1 || empty[0] !== 1'b0) begin
      errors++; $display("FAIL flush_pre: valid=%b empty=%b, required 1 0", pulse_valid[0], empty[0]);
    end
    flush_v[0] = 1'b1;
    tick();
    flush_v[0] = 1'b0;
    checks++;
    if (empty[0] !== 1'b1 || pulse_valid[0] !== 1'b0 || empty[1] !== 1'b0) begin
      errors++; $display("FAIL flush_post: empty0=%b valid0=%b empty1=%b, required 1 0 0", empty[0], pulse_valid[0], empty[1]);
    end
    $display("flush: ch0 emptied, ch1 empty=%b", empty[1]);
    flush_v[1] = 1'b1;
    tick();
    flush_v[1] = 1'b0;
    run = 1'b1;
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      run = ($urandom_range(0, 7) != 0);
      time_clr = ($urandom_range(0, 63) == 0);
      wr_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        set_write(int'($urandom_range(0, 7)), rand_desc(mnow + TW'($urandom_range(0, 12)) - TW'(3)));
      end
      for (int c = 0; c < NCH; c++) begin
        pulse_ready[c] = ($urandom_range(0, 3) != 0);
        late_clr[c]    = ($urandom_range(0, 15) == 0);
`ifdef PULSE_SCHED_FLUSH_EN
        flush_v[c]     = ($urandom_range(0, 31) == 0);
`endif
      end
      #1;
      checks++;
      if (wr_ready !== m_wr_ready()) begin
        errors++; $display("FAIL rand_wr_ready n%0d ch%0d: got %b, required %b", n, wr_ch, wr_ready, m_wr_ready());
      end
      tick();
      checks++;
      if (now !== mnow) begin errors++; $display("FAIL rand_now n%0d: got %0d, required %0d", n, now, mnow); end
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (pulse_valid[c] !== mvalid[c] || late[c] !== mlate[c] ||
            full[c] !== (mq[c].size() == DEP) || empty[c] !== (mq[c].size() == 0)) begin
          errors++;
          $display("FAIL rand_status n%0d ch%0d: valid=%b late=%b full=%b empty=%b, required %b %b %b %b",
                   n, c, pulse_valid[c], late[c], full[c], empty[c],
                   mvalid[c], mlate[c], mq[c].size() == DEP, mq[c].size() == 0);
        end
        if (mvalid[c]) begin
          checks++;
          if (got_desc(c) !== mout[c]) begin
            errors++; $display("FAIL rand_data n%0d ch%0d: got %h, required %h", n, c, got_desc(c), mout[c]);
          end
        end
      end
      if (n % 50 == 0) $display("random n=%0d now=%0d valid=%b late=%b", n, now, pulse_valid, late);
    end
    wr_valid = 1'b0;
    pulse_ready = '0;
    late_clr = '0;
    flush_v = '0;
  endtask

  initial begin
    test_reset();
    test_ontime();
    test_late();
    test_full();
    test_back_to_back();
    test_wrap();
`ifdef PULSE_SCHED_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
